// File: rtl/mips_pkg.sv
// Shared MIPS encodings and width defaults for the ID/EX stage, the ALU and the bench.
// classify() maps an opcode/funct pair onto the operand-routing class the stage needs.
package mips_pkg;

  localparam int SIZEDATA_D = 8;
  localparam int SIZEOP_D   = 6;
  localparam int SIZEREG_D  = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [2:0] {
    CLS_ILL, CLS_SHIFT, CLS_SHIFTV, CLS_RR, CLS_IMM, CLS_LUI
  } op_cls_e;

  function automatic op_cls_e classify(input logic [5:0] opcode, input logic [5:0] funct);
    op_cls_e cls;
    cls = CLS_ILL;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SLL, FN_SRL, FN_SRA:                                  cls = CLS_SHIFT;
        FN_SLLV, FN_SRLV, FN_SRAV:                               cls = CLS_SHIFTV;
        FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: cls = CLS_RR;
        default:                                                 cls = CLS_ILL;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: cls = CLS_IMM;
        OP_LUI:                                     cls = CLS_LUI;
        default:                                    cls = CLS_ILL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass mux: the youngest in-flight writer of a nonzero source register wins,
// EX/MEM ahead of MEM/WB, otherwise the register-file read data is used.
module forward_unit #(
  parameter int SIZEDATA = 8,
  parameter int SIZEREG  = 5
) (
  input  logic [SIZEREG-1:0]  src_addr,
  input  logic [SIZEDATA-1:0] rf_data,
  input  logic                exmem_wr,
  input  logic [SIZEREG-1:0]  exmem_addr,
  input  logic [SIZEDATA-1:0] exmem_data,
  input  logic                memwb_wr,
  input  logic [SIZEREG-1:0]  memwb_addr,
  input  logic [SIZEDATA-1:0] memwb_data,
  output logic [SIZEDATA-1:0] data
);

  always_comb begin
    data = rf_data;
    // r0 is hardwired zero, so a write aimed at it never bypasses.
    if (src_addr != '0) begin
      if (exmem_wr && (exmem_addr == src_addr))      data = exmem_data;
      else if (memwb_wr && (memwb_addr == src_addr)) data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards operands, routes them per instruction class and
// registers ALU inputs with flush > stall > load priority.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int SIZEDATA = SIZEDATA_D,
  parameter int SIZEOP   = SIZEOP_D,
  parameter int SIZEREG  = SIZEREG_D
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [SIZEOP-1:0]   i_opcode,
  input  logic [SIZEOP-1:0]   i_funct,
  input  logic [SIZEREG-1:0]  i_rs_addr,
  input  logic [SIZEREG-1:0]  i_rt_addr,
  input  logic [SIZEREG-1:0]  i_rd_addr,
  input  logic [SIZEDATA-1:0] i_rs_data,
  input  logic [SIZEDATA-1:0] i_rt_data,
  input  logic [SIZEDATA-1:0] i_imm,
  input  logic [4:0]          i_shamt,
  input  logic                i_exmem_wr,
  input  logic                i_memwb_wr,
  input  logic [SIZEREG-1:0]  i_exmem_addr,
  input  logic [SIZEREG-1:0]  i_memwb_addr,
  input  logic [SIZEDATA-1:0] i_exmem_data,
  input  logic [SIZEDATA-1:0] i_memwb_data,
  output logic [SIZEDATA-1:0] o_datoa,
  output logic [SIZEDATA-1:0] o_datob,
  output logic [SIZEOP-1:0]   o_alu_op,
  output logic [SIZEREG-1:0]  o_wr_addr,
  output logic                o_reg_write,
  output logic                o_valid,
  output logic                o_illegal
);

  logic [SIZEDATA-1:0] fwd_rs, fwd_rt;
  logic [SIZEDATA+4:0] shamt_ext;
  op_cls_e             cls;

  logic [SIZEDATA-1:0] nxt_a, nxt_b;
  logic [SIZEOP-1:0]   nxt_op;
  logic [SIZEREG-1:0]  nxt_wr;
  logic                nxt_rw, nxt_v, nxt_ill;

  forward_unit #(.SIZEDATA(SIZEDATA), .SIZEREG(SIZEREG)) u_fwd_rs (
    .src_addr  (i_rs_addr),
    .rf_data   (i_rs_data),
    .exmem_wr  (i_exmem_wr),
    .exmem_addr(i_exmem_addr),
    .exmem_data(i_exmem_data),
    .memwb_wr  (i_memwb_wr),
    .memwb_addr(i_memwb_addr),
    .memwb_data(i_memwb_data),
    .data      (fwd_rs)
  );

  forward_unit #(.SIZEDATA(SIZEDATA), .SIZEREG(SIZEREG)) u_fwd_rt (
    .src_addr  (i_rt_addr),
    .rf_data   (i_rt_data),
    .exmem_wr  (i_exmem_wr),
    .exmem_addr(i_exmem_addr),
    .exmem_data(i_exmem_data),
    .memwb_wr  (i_memwb_wr),
    .memwb_addr(i_memwb_addr),
    .memwb_data(i_memwb_data),
    .data      (fwd_rt)
  );

  // Zero-extend first, then keep the low SIZEDATA bits so narrow datapaths truncate.
  assign shamt_ext = {{SIZEDATA{1'b0}}, i_shamt};
  assign cls       = classify(i_opcode[5:0], i_funct[5:0]);

  always_comb begin
    nxt_a   = '0;
    nxt_b   = '0;
    nxt_op  = '0;
    nxt_wr  = '0;
    nxt_rw  = 1'b0;
    nxt_v   = 1'b0;
    nxt_ill = 1'b0;
    if (i_valid) begin
      if (cls == CLS_ILL) begin
        nxt_ill = 1'b1;
      end else begin
        nxt_v  = 1'b1;
        nxt_op = (i_opcode == '0) ? i_funct : i_opcode;
        case (cls)
          CLS_SHIFT:  begin nxt_a = fwd_rt; nxt_b = shamt_ext[SIZEDATA-1:0]; nxt_wr = i_rd_addr; end
          CLS_SHIFTV: begin nxt_a = fwd_rt; nxt_b = fwd_rs;                  nxt_wr = i_rd_addr; end
          CLS_RR:     begin nxt_a = fwd_rs; nxt_b = fwd_rt;                  nxt_wr = i_rd_addr; end
          CLS_IMM:    begin nxt_a = fwd_rs; nxt_b = i_imm;                   nxt_wr = i_rt_addr; end
          CLS_LUI:    begin nxt_a = i_imm;  nxt_b = SIZEDATA'(SIZEDATA / 2); nxt_wr = i_rt_addr; end
          default:    begin nxt_a = '0;     nxt_b = '0;                      nxt_wr = '0;        end
        endcase
        nxt_rw = (nxt_wr != '0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_datoa     <= '0;
      o_datob     <= '0;
      o_alu_op    <= '0;
      o_wr_addr   <= '0;
      o_reg_write <= 1'b0;
      o_valid     <= 1'b0;
      o_illegal   <= 1'b0;
    end else if (i_flush) begin
      o_datoa     <= '0;
      o_datob     <= '0;
      o_alu_op    <= '0;
      o_wr_addr   <= '0;
      o_reg_write <= 1'b0;
      o_valid     <= 1'b0;
      o_illegal   <= 1'b0;
    end else if (!i_stall) begin
      o_datoa     <= nxt_a;
      o_datob     <= nxt_b;
      o_alu_op    <= nxt_op;
      o_wr_addr   <= nxt_wr;
      o_reg_write <= nxt_rw;
      o_valid     <= nxt_v;
      o_illegal   <= nxt_ill;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised scoreboard bench for id_ex_stage: a driver pushes reference-model results,
// a negedge monitor pops and compares against the registered outputs.
module tb_id_ex_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [4:0] wr;
    logic       rw;
    logic       v;
    logic       ill;
  } exp_t;

  logic       clk, rst_n, valid, stall, flush;
  logic [5:0] opcode, funct;
  logic [4:0] rs_a, rt_a, rd_a, shamt, exmem_addr, memwb_addr;
  logic [7:0] rs_d, rt_d, imm, exmem_d, memwb_d;
  logic       exmem_wr, memwb_wr;
  logic [7:0] datoa, datob;
  logic [5:0] alu_op;
  logic [4:0] wr_addr;
  logic       reg_write, o_valid, illegal;

  exp_t q[$];
  exp_t mdl;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_opcode(opcode), .i_funct(funct),
    .i_rs_addr(rs_a), .i_rt_addr(rt_a), .i_rd_addr(rd_a),
    .i_rs_data(rs_d), .i_rt_data(rt_d), .i_imm(imm), .i_shamt(shamt),
    .i_exmem_wr(exmem_wr), .i_memwb_wr(memwb_wr),
    .i_exmem_addr(exmem_addr), .i_memwb_addr(memwb_addr),
    .i_exmem_data(exmem_d), .i_memwb_data(memwb_d),
    .o_datoa(datoa), .o_datob(datob), .o_alu_op(alu_op), .o_wr_addr(wr_addr),
    .o_reg_write(reg_write), .o_valid(o_valid), .o_illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fwd(input logic [4:0] addr, input logic [7:0] rf);
    if (addr == 5'd0) return rf;
    if (exmem_wr && exmem_addr == addr) return exmem_d;
    if (memwb_wr && memwb_addr == addr) return memwb_d;
    return rf;
  endfunction

  // Reference: what the stage should hold after the coming edge, given current inputs.
  function automatic exp_t model_next(input exp_t prev);
    exp_t e;
    logic [7:0] fa, fb;
    bit r;
    e = '0;
    if (!rst_n || flush) return '0;
    if (stall) return prev;
    if (!valid) return '0;
    fa = fwd(rs_a, rs_d);
    fb = fwd(rt_a, rt_d);
    r  = (opcode == 6'd0);
    e.op = r ? funct : opcode;
    if (r && funct inside {FN_SLL, FN_SRL, FN_SRA}) begin
      e.a = fb; e.b = {3'b000, shamt}; e.wr = rd_a;
    end else if (r && funct inside {FN_SLLV, FN_SRLV, FN_SRAV}) begin
      e.a = fb; e.b = fa; e.wr = rd_a;
    end else if (r && funct inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT}) begin
      e.a = fa; e.b = fb; e.wr = rd_a;
    end else if (!r && opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI}) begin
      e.a = fa; e.b = imm; e.wr = rt_a;
    end else if (opcode == OP_LUI) begin
      e.a = imm; e.b = 8'd4; e.wr = rt_a;
    end else begin
      e = '0;
      e.ill = 1'b1;
      return e;
    end
    e.v  = 1'b1;
    e.rw = (e.wr != 5'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {datoa, datob, alu_op, wr_addr, reg_write, o_valid, illegal};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL sb t=%0t got a=%h b=%h op=%b wr=%0d rw=%b v=%b ill=%b want a=%h b=%h op=%b wr=%0d rw=%b v=%b ill=%b",
                 $time, act.a, act.b, act.op, act.wr, act.rw, act.v, act.ill,
                 e.a, e.b, e.op, e.wr, e.rw, e.v, e.ill);
      end
    end
  end

  task automatic cyc();
    mdl = model_next(mdl);
    q.push_back(mdl);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {datoa, datob, alu_op, wr_addr, reg_write, o_valid, illegal}, 32'd0);
  endtask

  task automatic set_rr(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [7:0] rsd, input logic [7:0] rtd);
    valid = 1'b1; opcode = OP_RTYPE; funct = fn;
    rs_a = rs; rt_a = rt; rd_a = rd; rs_d = rsd; rt_d = rtd;
  endtask

  task automatic rand_inputs();
    logic [5:0] ops[8] = '{OP_RTYPE, OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, 6'b100011};
    logic [5:0] fns[10] = '{FN_SLL, FN_SRA, FN_SRLV, FN_SRAV, FN_ADDU, FN_SUBU, FN_NOR, FN_SLT, FN_XOR, 6'b111111};
    valid      = ($urandom_range(0, 9) != 0);
    stall      = ($urandom_range(0, 4) == 0);
    flush      = ($urandom_range(0, 9) == 0);
    opcode     = ($urandom_range(0, 19) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
    funct      = fns[$urandom_range(0, 9)];
    rs_a       = 5'($urandom_range(0, 5));
    rt_a       = 5'($urandom_range(0, 5));
    rd_a       = 5'($urandom_range(0, 5));
    shamt      = 5'($urandom);
    rs_d       = 8'($urandom);
    rt_d       = 8'($urandom);
    imm        = 8'($urandom);
    exmem_wr   = 1'($urandom);
    memwb_wr   = 1'($urandom);
    exmem_addr = 5'($urandom_range(0, 5));
    memwb_addr = 5'($urandom_range(0, 5));
    exmem_d    = 8'($urandom);
    memwb_d    = 8'($urandom);
  endtask

  initial begin
    rst_n = 1'b1; valid = 0; stall = 0; flush = 0; opcode = 0; funct = 0;
    rs_a = 0; rt_a = 0; rd_a = 0; shamt = 0; rs_d = 0; rt_d = 0; imm = 0;
    exmem_wr = 0; memwb_wr = 0; exmem_addr = 0; memwb_addr = 0; exmem_d = 0; memwb_d = 0;
    mdl = '0;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_init");
    @(negedge clk); #1;
    rst_n = 1'b1;

    set_rr(FN_ADDU, 5'd1, 5'd2, 5'd7, 8'h05, 8'h03);
    cyc();
    chk("addu_a", datoa, 8'h05); chk("addu_b", datob, 8'h03); chk("addu_op", alu_op, FN_ADDU);
    chk("addu_ctl", {wr_addr, reg_write, o_valid}, {5'd7, 1'b1, 1'b1});

    set_rr(FN_SRA, 5'd1, 5'd2, 5'd3, 8'h00, 8'hF0); shamt = 5'd2;
    cyc();
    chk("sra_ab", {datoa, datob}, {8'hF0, 8'h02}); chk("sra_op", alu_op, 6'b000011);

    opcode = OP_LUI; imm = 8'h0A; rt_a = 5'd4;
    cyc();
    chk("lui_ab", {datoa, datob}, {8'h0A, 8'h04}); chk("lui_wr", wr_addr, 5'd4);

    set_rr(FN_ADDU, 5'd3, 5'd2, 5'd9, 8'h33, 8'h01);
    exmem_wr = 1; exmem_addr = 5'd3; exmem_d = 8'h7F;
    memwb_wr = 1; memwb_addr = 5'd3; memwb_d = 8'h11;
    cyc(); chk("fwd_exmem", datoa, 8'h7F);
    exmem_wr = 0;
    cyc(); chk("fwd_memwb", datoa, 8'h11);
    exmem_wr = 1; rs_a = 5'd0; exmem_addr = 5'd0; memwb_addr = 5'd0;
    cyc(); chk("fwd_r0", datoa, 8'h33);
    exmem_wr = 0; memwb_wr = 0;

    set_rr(FN_SUBU, 5'd1, 5'd2, 5'd5, 8'hA5, 8'h5A);
    cyc();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs_d = 8'($urandom); rt_d = 8'($urandom); funct = FN_OR;
      cyc();
      chk("stall_hold", {datoa, datob, alu_op}, {8'hA5, 8'h5A, FN_SUBU});
    end
    flush = 1;
    cyc(); chk_zero("stall_flush");
    stall = 0; flush = 0;

    set_rr(6'b111111, 5'd1, 5'd2, 5'd5, 8'h12, 8'h34);
    cyc(); chk("illegal_on", {illegal, o_valid, reg_write}, {1'b1, 1'b0, 1'b0});
    funct = FN_AND;
    cyc(); chk("illegal_off", {illegal, o_valid}, {1'b0, 1'b1});

    stall = 1;
    cyc();
    rst_n = 1'b0;
    #1 chk_zero("reset_async_stall");
    mdl = '0;
    cyc();
    rst_n = 1'b1; stall = 0;
    set_rr(FN_XOR, 5'd1, 5'd2, 5'd6, 8'h0F, 8'hF0);
    cyc(); chk("post_reset_load", {datoa, datob, wr_addr}, {8'h0F, 8'hF0, 5'd6});

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cyc();
    end

    valid = 0; stall = 0; flush = 0;
    cyc();
    @(negedge clk); #1;
    chk("sb_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
